seq_det_scheduler: RTL and testbench
====================================

# seq_det_scheduler

Round-robin scheduler that time-shares one serial "1001" pattern-detection engine among `N_REQ` requesters. Each requester presents a parallel frame. The scheduler grants one requester, clears the engine, and shifts the frame in MSB-first. It counts non-overlapping matches and returns the count with a one-cycle done pulse. It sits between frame-producing clients and the single detector engine it owns.

## Interface
- `N_REQ`, 4: number of requesters (≥2).
- `FRAME_W`, 8: bits per frame (≥4).
- `CNT_W`, derived localparam `$clog2(FRAME_W+1)`: match-count width.
- `ID_W`, derived localparam `$clog2(N_REQ)`: requester index width.
- `clk` in 1: single clock; all logic on posedge.
- `rst` in 1: synchronous, active-high reset.
- `req` in N_REQ: per-requester request level.
- `frame_data` in N_REQ*FRAME_W: frame for requester i at bits [i*FRAME_W +: FRAME_W].
- `grant` out N_REQ: one-hot; held for the whole service of the granted requester.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse; result valid.
- `done_id` out ID_W: index of the requester serviced; valid with `done`.
- `match_cnt` out CNT_W: matches found in the frame; held until the next `done`.

## Operation
- FSM states: IDLE, LOAD, SHIFT, DRAIN, REPORT.
- IDLE:
  - If `req` != 0, pick the first set bit searching from `last_id+1` upward, with wrap.
  - Capture that requester's frame into the shift register, set `grant`, go to LOAD.
  - Otherwise stay in IDLE.
- `req` and `frame_data` are sampled only in IDLE. Changes during service are ignored.
- LOAD:
  - Assert `det_clr` for one cycle. The engine is reset with `rst | det_clr`, so its state goes to s0 and its output to 0.
  - Clear the bit counter and match counter. Go to SHIFT.
- SHIFT:
  - Drive the shift-register MSB to the engine input and shift left each cycle.
  - Stay in SHIFT for exactly FRAME_W cycles, then go to DRAIN.
- Engine output is registered, so a match on input bit k is visible one cycle later.
- Match counter increments on every cycle in SHIFT or DRAIN where the engine output is 1. The counter is sized so it cannot overflow.
- DRAIN: one cycle, to capture a match on the last bit. Go to REPORT.
- REPORT:
  - `done`=1; `match_cnt` and `done_id` are updated.
  - `last_id` ← the granted index. Go to IDLE; `grant` clears on that edge.
- Engine input is 0 outside SHIFT.
- Matching is non-overlapping: after a match, the engine restarts from s0 and the trailing 1 is not reused.
- A requester must drop `req` in the REPORT cycle. `req` still high in IDLE is a new request.

## Timing
- Reset values: `grant`=0, `busy`=0, `done`=0, `done_id`=0, `match_cnt`=0, state=IDLE, `last_id`=N_REQ-1 (so the first grant searches from index 0).
- Latency: with `req` sampled at edge E0, `grant` and `busy` rise after E0, and `done` is high in cycle E0+FRAME_W+3 (LOAD 1, SHIFT FRAME_W, DRAIN 1, REPORT 1).
- Back-to-back: minimum request-to-request spacing is FRAME_W+4 cycles, because IDLE costs one cycle.
- Reset mid-operation: all outputs and state return to reset values on the next edge. The partial count is discarded and no `done` is issued.
- Simultaneous requests resolve purely by the round-robin pointer, never fixed priority.

## Structure
- Package `seq_sched_pkg`: FSM state encoding constants, and a rotate-priority helper function.
- Sub-module `seq1001_engine` (clk, rst, in, out):
  - 4-state Mealy 1001 detector with a registered output.
  - Instantiated once and cleared via its `rst`.
- Top level holds the arbiter pointer, shift register, bit and match counters, and output registers.

## Test plan
- Single request, `req`=4'b0001, frame 8'b1001_1001 → `grant`=0001, `done` 11 cycles after sampling, `match_cnt`=2, `done_id`=0.
- Non-overlap, frame 8'b1001_0010 → `match_cnt`=1 (not 2). Frame 8'b0000_0000 → 0. Frame 8'b1100_1000 → 1.
- After reset, `req`=4'b1111 held and re-raised each IDLE → grants in order 0001, 0010, 0100, 1000, 0001. `done_id` follows 0,1,2,3,0.
- Fairness: id 2 is serviced, then `req`=4'b0101 → next grant is 0001 (search from 3 wraps to 0), then 0100.
- Frame with match on the final bit, 8'b0000_1001 → `match_cnt`=1, confirming the DRAIN capture. Changing `frame_data` during SHIFT does not alter the result.
- Assert `rst` during SHIFT → next cycle all outputs 0 and no `done`. Then a new request with frame 8'b1001_1001 → `grant`=0001, `match_cnt`=2 (no stale engine state).

Source files
------------

// File: rtl/seq_det_scheduler_pkg.sv
// Shared definitions for the round-robin "1001" detection scheduler.
// Contents:
//   sched_state_e - scheduler FSM encoding (IDLE, LOAD, SHIFT, DRAIN, REPORT)
//   eng_state_e   - 1001 detector progress (nothing, "1", "10", "100")
//   rr_pick       - rotate-priority search used by the arbiter
package seq_sched_pkg;

    localparam int unsigned RR_MAX = 32;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SHIFT  = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_REPORT = 3'd4
    } sched_state_e;

    typedef enum logic [1:0] {
        ENG_S0 = 2'd0,
        ENG_S1 = 2'd1,
        ENG_S2 = 2'd2,
        ENG_S3 = 2'd3
    } eng_state_e;

    // First set bit of req[n-1:0] searching upward from last+1 with wrap.
    // Returns last when no bit is set; callers only use it when req != 0.
    function automatic int unsigned rr_pick(input logic [RR_MAX-1:0] req,
                                            input int unsigned n,
                                            input int unsigned last);
        int unsigned pick;
        int unsigned idx;
        logic        found;
        pick  = last;
        found = 1'b0;
        for (int unsigned k = 1; k <= RR_MAX; k++) begin
            idx = last + k;
            if (idx >= n) begin
                idx = idx - n;
            end else begin
                idx = idx;
            end
            if ((k <= n) && !found && req[idx[4:0]]) begin
                pick  = idx;
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/seq_det_scheduler_if.sv
// Client-facing bus of the scheduler.
//   req        - per-requester request level
//   frame_data - frame for requester i at [i*FRAME_W +: FRAME_W]
//   grant      - one-hot, held for the whole service
//   busy       - scheduler not idle
//   done       - one-cycle result strobe
//   done_id    - serviced requester, valid with done
//   match_cnt  - non-overlapping "1001" count, held until next done
// master: the requester side. slave: the scheduler.
interface seq_det_scheduler_if #(
    parameter int N_REQ   = 4,
    parameter int FRAME_W = 8
);
    localparam int CNT_W = $clog2(FRAME_W + 1);
    localparam int ID_W  = $clog2(N_REQ);

    logic [N_REQ-1:0]         req;
    logic [N_REQ*FRAME_W-1:0] frame_data;
    logic [N_REQ-1:0]         grant;
    logic                     busy;
    logic                     done;
    logic [ID_W-1:0]          done_id;
    logic [CNT_W-1:0]         match_cnt;

    modport master (
        output req, frame_data,
        input  grant, busy, done, done_id, match_cnt
    );

    modport slave (
        input  req, frame_data,
        output grant, busy, done, done_id, match_cnt
    );
endinterface

// File: rtl/seq_det_scheduler_engine.sv
// Serial Mealy "1001" detector with registered output.
//   clk - clock
//   rst - synchronous active-high clear (system reset or scheduler clear)
//   in  - serial input bit
//   out - high one cycle after the bit that completes "1001"
// After a match it restarts from S0, so the trailing 1 is not reused.
module seq1001_engine
    import seq_sched_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic out
);

    eng_state_e state_q, state_d;
    logic       out_q, match_s;

    // Next-state and match decode.
    always_comb begin
        state_d = state_q;
        match_s = 1'b0;
        case (state_q)
            ENG_S0: begin
                if (in) state_d = ENG_S1;
                else    state_d = ENG_S0;
            end
            ENG_S1: begin
                if (in) state_d = ENG_S1;
                else    state_d = ENG_S2;
            end
            ENG_S2: begin
                if (in) state_d = ENG_S1;
                else    state_d = ENG_S3;
            end
            ENG_S3: begin
                // Either outcome returns to S0: match consumes the 1, "1000" breaks the run.
                state_d = ENG_S0;
                if (in) match_s = 1'b1;
                else    match_s = 1'b0;
            end
            default: begin
                state_d = ENG_S0;
                match_s = 1'b0;
            end
        endcase
    end

    // State and registered output.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ENG_S0;
            out_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= match_s;
        end
    end

    assign out = out_q;

endmodule

// File: rtl/seq_det_scheduler.sv
// Round-robin scheduler sharing one "1001" detector among N_REQ requesters.
//   clk - clock, rst - synchronous active-high reset
//   bus - seq_det_scheduler_if.slave (req/frame_data in; grant, busy,
//         done, done_id, match_cnt out, all registered)
// Service sequence: IDLE -> LOAD (clear engine) -> SHIFT (FRAME_W bits,
// MSB first) -> DRAIN (catch last-bit match) -> REPORT (done pulse).
module seq_det_scheduler
    import seq_sched_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int FRAME_W = 8
)(
    input  logic                clk,
    input  logic                rst,
    seq_det_scheduler_if.slave  bus
);

    localparam int CNT_W = $clog2(FRAME_W + 1);
    localparam int ID_W  = $clog2(N_REQ);
    localparam int BIT_W = $clog2(FRAME_W);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_W - 1);

    sched_state_e       state_q, state_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [ID_W-1:0]    gid_q, gid_d;
    logic [ID_W-1:0]    last_q, last_d;
    logic [FRAME_W-1:0] sreg_q, sreg_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [CNT_W-1:0]   mcnt_q, mcnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [ID_W-1:0]    done_id_q, done_id_d;
    logic [CNT_W-1:0]   match_cnt_q, match_cnt_d;
    logic [ID_W-1:0]    pick_s;
    logic               det_clr_s, eng_in_s, eng_out_s, eng_rst_s;
    logic [CNT_W-1:0]   eng_inc_s;

    assign pick_s    = ID_W'(rr_pick({{(RR_MAX-N_REQ){1'b0}}, bus.req},
                                     N_REQ, 32'(last_q)));
    assign eng_rst_s = rst | det_clr_s;
    assign eng_inc_s = {{(CNT_W-1){1'b0}}, eng_out_s};

    seq1001_engine u_engine (
        .clk (clk),
        .rst (eng_rst_s),
        .in  (eng_in_s),
        .out (eng_out_s)
    );

    // FSM next-state, datapath next values and engine controls.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        gid_d       = gid_q;
        last_d      = last_q;
        sreg_d      = sreg_q;
        bit_d       = bit_q;
        mcnt_d      = mcnt_q;
        done_d      = 1'b0;
        done_id_d   = done_id_q;
        match_cnt_d = match_cnt_q;
        det_clr_s   = 1'b0;
        eng_in_s    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.req != '0) begin
                    gid_d   = pick_s;
                    grant_d = N_REQ'(1) << pick_s;
                    sreg_d  = bus.frame_data[pick_s*FRAME_W +: FRAME_W];
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                det_clr_s = 1'b1;
                bit_d     = '0;
                mcnt_d    = '0;
                state_d   = ST_SHIFT;
            end
            ST_SHIFT: begin
                eng_in_s = sreg_q[FRAME_W-1];
                sreg_d   = {sreg_q[FRAME_W-2:0], 1'b0};
                mcnt_d   = mcnt_q + eng_inc_s;
                if (bit_q == LAST_BIT) begin
                    bit_d   = '0;
                    state_d = ST_DRAIN;
                end else begin
                    bit_d   = bit_q + BIT_W'(1);
                    state_d = ST_SHIFT;
                end
            end
            ST_DRAIN: begin
                // Result registers load here so they are valid alongside done in REPORT.
                mcnt_d      = mcnt_q + eng_inc_s;
                match_cnt_d = mcnt_q + eng_inc_s;
                done_id_d   = gid_q;
                done_d      = 1'b1;
                state_d     = ST_REPORT;
            end
            ST_REPORT: begin
                last_d  = gid_q;
                grant_d = '0;
                state_d = ST_IDLE;
            end
            default: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            gid_q       <= '0;
            last_q      <= ID_W'(N_REQ - 1);
            sreg_q      <= '0;
            bit_q       <= '0;
            mcnt_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            done_id_q   <= '0;
            match_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            gid_q       <= gid_d;
            last_q      <= last_d;
            sreg_q      <= sreg_d;
            bit_q       <= bit_d;
            mcnt_q      <= mcnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            done_id_q   <= done_id_d;
            match_cnt_q <= match_cnt_d;
        end
    end

    assign bus.grant     = grant_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.done_id   = done_id_q;
    assign bus.match_cnt = match_cnt_q;

endmodule

// File: tb/tb_seq_det_scheduler.sv
// Directed testbench for seq_det_scheduler (N_REQ=4, FRAME_W=8).
module tb_seq_det_scheduler;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    seq_det_scheduler_if #(.N_REQ(4), .FRAME_W(8)) bus ();

    seq_det_scheduler #(.N_REQ(4), .FRAME_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive a request so that the next posedge (E0) samples it in IDLE.
    task automatic start_req(input logic [3:0] r, input logic [31:0] frames);
        repeat (2) @(negedge clk);
        bus.req        = r;
        bus.frame_data = frames;
    endtask

    // Wait (bounded) for done; edges counts posedges consumed, sampled #1 after.
    task automatic wait_done(output int edges, output bit to);
        edges = 0;
        to    = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            edges++;
            if (bus.done === 1'b1) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req = 4'b0000;
        bus.frame_data = 32'h0000_0000;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (bus.grant !== 4'b0000) begin n_fail++; $display("FAIL reset_grant: got %b expected %b", bus.grant, 4'b0000); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected %b", bus.busy, 1'b0); end
        n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected %b", bus.done, 1'b0); end
        n_checks++; if (bus.done_id !== 2'd0) begin n_fail++; $display("FAIL reset_done_id: got %0d expected %0d", bus.done_id, 0); end
        n_checks++; if (bus.match_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_match_cnt: got %0d expected %0d", bus.match_cnt, 0); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single();
        int edges;
        bit to;
        start_req(4'b0001, 32'h0000_0099);
        @(posedge clk);  // E0
        #1;
        n_checks++; if (bus.grant !== 4'b0001) begin n_fail++; $display("FAIL single_grant: got %b expected %b", bus.grant, 4'b0001); end
        n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b expected %b", bus.busy, 1'b1); end
        wait_done(edges, to);
        // LOAD + 8 SHIFT + DRAIN: done appears 10 edges after E0 (11th cycle).
        n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL single_timeout: got %b expected %b", to, 1'b0); end
        n_checks++; if (edges !== 10) begin n_fail++; $display("FAIL single_latency: got %0d expected %0d", edges, 10); end
        n_checks++; if (bus.match_cnt !== 4'd2) begin n_fail++; $display("FAIL single_match_cnt: got %0d expected %0d", bus.match_cnt, 2); end
        n_checks++; if (bus.done_id !== 2'd0) begin n_fail++; $display("FAIL single_done_id: got %0d expected %0d", bus.done_id, 0); end
        n_checks++; if (bus.grant !== 4'b0001) begin n_fail++; $display("FAIL single_grant_report: got %b expected %b", bus.grant, 4'b0001); end
        bus.req = 4'b0000;
        @(posedge clk);
        #1;
        n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL single_done_pulse: got %b expected %b", bus.done, 1'b0); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_idle: got %b expected %b", bus.busy, 1'b0); end
        n_checks++; if (bus.grant !== 4'b0000) begin n_fail++; $display("FAIL single_grant_clear: got %b expected %b", bus.grant, 4'b0000); end
        n_checks++; if (bus.match_cnt !== 4'd2) begin n_fail++; $display("FAIL single_match_hold: got %0d expected %0d", bus.match_cnt, 2); end
    endtask

    task automatic test_patterns();
        logic [7:0] frm [4];
        logic [3:0] exp [4];
        int  edges;
        bit  to;
        frm[0] = 8'b1001_0010; exp[0] = 4'd1;
        frm[1] = 8'b0000_0000; exp[1] = 4'd0;
        frm[2] = 8'b1100_1000; exp[2] = 4'd1;
        frm[3] = 8'b0000_1001; exp[3] = 4'd1;
        for (int i = 0; i < 4; i++) begin
            start_req(4'b0001, {24'h000000, frm[i]});
            wait_done(edges, to);
            bus.req = 4'b0000;
            n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL pattern%0d_timeout: got %b expected %b", i, to, 1'b0); end
            n_checks++; if (bus.match_cnt !== exp[i]) begin n_fail++; $display("FAIL pattern%0d_match_cnt: got %0d expected %0d", i, bus.match_cnt, exp[i]); end
        end
    endtask

    task automatic test_frame_change();
        int edges;
        bit to;
        start_req(4'b0001, 32'h0000_0009);
        repeat (4) @(posedge clk);  // E0, LOAD, into SHIFT
        #1;
        bus.frame_data = 32'h0000_0099;
        bus.req        = 4'b1111;
        wait_done(edges, to);
        bus.req = 4'b0000;
        n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL frame_change_timeout: got %b expected %b", to, 1'b0); end
        n_checks++; if (bus.match_cnt !== 4'd1) begin n_fail++; $display("FAIL frame_change_match_cnt: got %0d expected %0d", bus.match_cnt, 1); end
        n_checks++; if (bus.done_id !== 2'd0) begin n_fail++; $display("FAIL frame_change_done_id: got %0d expected %0d", bus.done_id, 0); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_g [5];
        logic [1:0] exp_id [5];
        logic [3:0] exp_c [5];
        int  edges;
        bit  to;
        exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100; exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;
        exp_id[0] = 2'd0; exp_id[1] = 2'd1; exp_id[2] = 2'd2; exp_id[3] = 2'd3; exp_id[4] = 2'd0;
        exp_c[0] = 4'd2; exp_c[1] = 4'd0; exp_c[2] = 4'd1; exp_c[3] = 4'd1; exp_c[4] = 4'd2;
        // Fresh reset so the pointer starts at index 0.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        // Frames: id3=0000_1001, id2=1001_0000, id1=0000_0000, id0=1001_1001.
        start_req(4'b1111, 32'h0990_0099);
        for (int i = 0; i < 5; i++) begin
            wait_done(edges, to);
            if (i == 4) bus.req = 4'b0000;
            n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL rr%0d_timeout: got %b expected %b", i, to, 1'b0); end
            n_checks++; if (bus.grant !== exp_g[i]) begin n_fail++; $display("FAIL rr%0d_grant: got %b expected %b", i, bus.grant, exp_g[i]); end
            n_checks++; if (bus.done_id !== exp_id[i]) begin n_fail++; $display("FAIL rr%0d_done_id: got %0d expected %0d", i, bus.done_id, exp_id[i]); end
            n_checks++; if (bus.match_cnt !== exp_c[i]) begin n_fail++; $display("FAIL rr%0d_match_cnt: got %0d expected %0d", i, bus.match_cnt, exp_c[i]); end
            if (i > 0) begin
                n_checks++; if (edges !== 12) begin n_fail++; $display("FAIL rr%0d_spacing: got %0d expected %0d", i, edges, 12); end
            end
        end
    endtask

    task automatic test_fairness();
        int edges;
        bit to;
        start_req(4'b0100, 32'h0000_0000);
        wait_done(edges, to);
        n_checks++; if (bus.done_id !== 2'd2) begin n_fail++; $display("FAIL fair_first_id: got %0d expected %0d", bus.done_id, 2); end
        bus.req = 4'b0101;  // raised in REPORT: next IDLE searches from 3
        wait_done(edges, to);
        n_checks++; if (bus.grant !== 4'b0001) begin n_fail++; $display("FAIL fair_wrap_grant: got %b expected %b", bus.grant, 4'b0001); end
        n_checks++; if (bus.done_id !== 2'd0) begin n_fail++; $display("FAIL fair_wrap_id: got %0d expected %0d", bus.done_id, 0); end
        wait_done(edges, to);
        bus.req = 4'b0000;
        n_checks++; if (bus.grant !== 4'b0100) begin n_fail++; $display("FAIL fair_next_grant: got %b expected %b", bus.grant, 4'b0100); end
        n_checks++; if (bus.done_id !== 2'd2) begin n_fail++; $display("FAIL fair_next_id: got %0d expected %0d", bus.done_id, 2); end
    endtask

    task automatic test_reset_mid();
        int edges;
        int n_done;
        bit to;
        start_req(4'b0010, 32'h0000_FFFF);
        bus.req = 4'b0010;
        repeat (5) @(posedge clk);  // well into SHIFT
        @(negedge clk);
        rst = 1'b1;
        bus.req = 4'b0000;
        @(posedge clk);
        #1;
        n_checks++; if (bus.grant !== 4'b0000) begin n_fail++; $display("FAIL midrst_grant: got %b expected %b", bus.grant, 4'b0000); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected %b", bus.busy, 1'b0); end
        n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL midrst_done: got %b expected %b", bus.done, 1'b0); end
        n_checks++; if (bus.match_cnt !== 4'd0) begin n_fail++; $display("FAIL midrst_match_cnt: got %0d expected %0d", bus.match_cnt, 0); end
        n_checks++; if (bus.done_id !== 2'd0) begin n_fail++; $display("FAIL midrst_done_id: got %0d expected %0d", bus.done_id, 0); end
        @(negedge clk);
        rst = 1'b0;
        n_done = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) n_done++;
        end
        n_checks++; if (n_done !== 0) begin n_fail++; $display("FAIL midrst_no_done: got %0d expected %0d", n_done, 0); end
        start_req(4'b0001, 32'h0000_0099);
        @(posedge clk);
        #1;
        n_checks++; if (bus.grant !== 4'b0001) begin n_fail++; $display("FAIL midrst_regrant: got %b expected %b", bus.grant, 4'b0001); end
        bus.req = 4'b0000;
        wait_done(edges, to);
        n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL midrst_timeout: got %b expected %b", to, 1'b0); end
        n_checks++; if (bus.match_cnt !== 4'd2) begin n_fail++; $display("FAIL midrst_match_cnt_new: got %0d expected %0d", bus.match_cnt, 2); end
        n_checks++; if (edges !== 10) begin n_fail++; $display("FAIL midrst_latency: got %0d expected %0d", edges, 10); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        bus.req        = 4'b0000;
        bus.frame_data = 32'h0000_0000;
        test_reset();
        test_single();
        test_patterns();
        test_frame_change();
        test_back_to_back();
        test_fairness();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
